// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32M multiply/divide unit for the execute stage.
// Multiplies use shift-add, divides use restoring shift-subtract, one bit per
// clock. The start/busy/done handshake lets the hazard logic stall the pipe.
//
// State table
//    state | meaning
//    IDLE  | waiting for start; operands and Funct3 latched on accept
//    PREP  | convert signed operands to magnitudes, record result sign
//    CALC  | one quotient/product bit per cycle, counter runs down to 0
//    FIN   | sign fixup, select the result half, pulse done on exit
//
// Ports
//    clk    : rising-edge clock
//    reset  : synchronous active-low reset
//    start  : request pulse, accepted only in IDLE
//    flush  : abort the in-flight operation
//    Funct3 : RV32M operation select
//    SrcA   : rs1 (multiplicand / dividend)
//    SrcB   : rs2 (multiplier / divisor)
//    busy   : operation in flight
//    done   : one-cycle pulse, Result valid
//    Result : final result, held until the next completion
module mdu_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  flush,
   input  logic [2:0]            Funct3,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] Result
);

   localparam int W = DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;

   state_t             state;
   logic [2:0]         op;
   logic [W-1:0]       opa;
   logic [W-1:0]       opb;
   logic [2*W-1:0]     work;
   logic [CNT_WIDTH-1:0] cnt;
   logic               neg;
   logic               special;

   // special cases are resolved straight from the input operands
   logic               in_div0;
   logic               in_ovf;
   logic [W-1:0]       spec_val;

   always_comb begin
      in_div0  = Funct3[2] && (SrcB == '0);
      in_ovf   = Funct3[2] && !Funct3[0] &&
                 (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
      spec_val = '0;
      if (in_div0)
         spec_val = Funct3[1] ? SrcA : '1;
      else if (in_ovf)
         spec_val = Funct3[1] ? '0 : SrcA;
   end

   // operand signedness from the latched opcode
   logic a_signed;
   logic b_signed;
   logic sa;
   logic sb;

   always_comb begin
      a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
      b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      sa       = a_signed && opa[W-1];
      sb       = b_signed && opb[W-1];
   end

   // one iteration step; work holds {acc/remainder, multiplier/quotient}
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_next;
   logic [W:0]     rem_sh;
   logic [W:0]     trial;
   logic [2*W-1:0] div_next;

   always_comb begin
      mul_sum  = {1'b0, work[2*W-1:W]} + (work[0] ? {1'b0, opa} : '0);
      mul_next = {mul_sum, work[W-1:1]};
      rem_sh   = work[2*W-1:W-1];
      trial    = rem_sh - {1'b0, opb};
      // a borrow out of the trial subtract means the divisor did not fit
      if (trial[W])
         div_next = {rem_sh[W-1:0], work[W-2:0], 1'b0};
      else
         div_next = {trial[W-1:0], work[W-2:0], 1'b1};
   end

   // sign fixup and result selection
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   lo_fix;
   logic [W-1:0]   hi_fix;
   logic [W-1:0]   fin_val;

   always_comb begin
      prod_fix = neg ? -work : work;
      lo_fix   = neg ? -work[W-1:0] : work[W-1:0];
      hi_fix   = neg ? -work[2*W-1:W] : work[2*W-1:W];
      fin_val  = '0;
      if (special)
         fin_val = work[W-1:0];
      else begin
         case (op)
            3'b000:                 fin_val = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: fin_val = prod_fix[2*W-1:W];
            3'b100, 3'b101:         fin_val = lo_fix;
            default:                fin_val = hi_fix;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         op      <= '0;
         opa     <= '0;
         opb     <= '0;
         work    <= '0;
         cnt     <= '0;
         neg     <= 1'b0;
         special <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         Result  <= '0;
      end else begin
         done <= 1'b0;
         // the completing edge out of FIN still delivers its result
         if (flush && state != FIN) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     op   <= Funct3;
                     opa  <= SrcA;
                     opb  <= SrcB;
                     busy <= 1'b1;
                     if (in_div0 || in_ovf) begin
                        special <= 1'b1;
                        work    <= {{W{1'b0}}, spec_val};
                        state   <= FIN;
                     end else begin
                        special <= 1'b0;
                        state   <= PREP;
                     end
                  end
               end
               PREP: begin
                  opa   <= sa ? -opa : opa;
                  opb   <= sb ? -opb : opb;
                  // remainder takes the dividend sign, everything else the xor
                  neg   <= (op[2] && op[1]) ? sa : (sa ^ sb);
                  work  <= {{W{1'b0}}, op[2] ? (sa ? -opa : opa) : (sb ? -opb : opb)};
                  cnt   <= CNT_WIDTH'(W);
                  state <= CALC;
               end
               CALC: begin
                  work <= op[2] ? div_next : mul_next;
                  cnt  <= cnt - CNT_WIDTH'(1);
                  if (cnt == CNT_WIDTH'(1))
                     state <= FIN;
               end
               FIN: begin
                  Result <= fin_val;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed plus randomized checks of mdu_sequencer against
// an arithmetic reference of the RV32M operations.
module tb_mdu_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic        flush;
   logic [2:0]  Funct3;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        busy;
   logic        done;
   logic [31:0] Result;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] last_res = '0;

   mdu_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .flush  (flush),
      .Funct3 (Funct3),
      .SrcA   (SrcA),
      .SrcB   (SrcB),
      .busy   (busy),
      .done   (done),
      .Result (Result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = '0;
      case (f)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin if (b == 0) return 32'hFFFF_FFFF; return 32'(sa / sb); end
         3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
         3'd6: begin if (b == 0) return a; return 32'(sa % sb); end
         default: begin if (b == 0) return a; return a % b; end
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op from IDLE (caller sits at posedge+1) and check it fully.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input bit poke);
      logic [31:0] exp;
      int          exp_lat;
      int          lat;
      bit          busy_ok;
      int          extra_done;
      exp     = model(f, a, b);
      exp_lat = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
      start = 1'b1; Funct3 = f; SrcA = a; SrcB = b;
      @(posedge clk); #1;
      start = 1'b0; SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom);
      check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
      lat = 0;
      busy_ok = 1'b1;
      while (!done && lat < 60) begin
         if (!busy) busy_ok = 1'b0;
         start = (poke && lat >= 3 && lat <= 6) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " result"}, Result, exp);
      check({tag, " busy_at_done"}, 32'(busy), 32'd0);
      check({tag, " busy_until_done"}, 32'(busy_ok), 32'd1);
      last_res = exp;
      extra_done = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done) extra_done++;
      end
      check({tag, " single_done"}, 32'(extra_done), 32'd0);
   endtask

   initial begin
      int n_done;
      reset = 1'b0; start = 1'b0; flush = 1'b0; Funct3 = '0; SrcA = '0; SrcB = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset result", Result, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      run_op("mul_neg",   3'd0, 32'd7,          32'hFFFF_FFFD, 1'b1);
      run_op("mulhu",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
      run_op("mulh",      3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
      run_op("mulhsu",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
      run_op("div",       3'd4, 32'hFFFF_FFF9,  32'd2,         1'b0);
      run_op("rem",       3'd6, 32'hFFFF_FFF9,  32'd2,         1'b0);
      run_op("divu",      3'd5, 32'hFFFF_FFF9,  32'd2,         1'b0);
      run_op("divu_zero", 3'd5, 32'd5,          32'd0,         1'b0);
      run_op("remu_zero", 3'd7, 32'd5,          32'd0,         1'b0);
      run_op("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
      run_op("rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
      run_op("div_zero",  3'd4, 32'hFFFF_FFF9,  32'd0,         1'b0);

      // flush on CALC cycle 10 of a DIV
      start = 1'b1; Funct3 = 3'd4; SrcA = 32'd1000; SrcB = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush busy", 32'(busy), 32'd0);
      check("flush done", 32'(done), 32'd0);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check("flush no_done", 32'(n_done), 32'd0);
      check("flush result_kept", Result, last_res);

      // flush together with start: request is dropped
      start = 1'b1; flush = 1'b1; Funct3 = 3'd0; SrcA = 32'd9; SrcB = 32'd9;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("flush_start busy", 32'(busy), 32'd0);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check("flush_start no_done", 32'(n_done), 32'd0);

      // reset mid-CALC
      start = 1'b1; Funct3 = 3'd0; SrcA = 32'd123; SrcB = 32'd456;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset done", 32'(done), 32'd0);
      check("midreset result", Result, 32'd0);
      run_op("mul_after_reset", 3'd0, 32'd3, 32'd4, 1'b0);

      // randomized operations
      for (int i = 0; i < 24; i++) begin
         logic [2:0]  f;
         logic [31:0] a;
         logic [31:0] b;
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 7) == 0) b = '0;
         if ($urandom_range(0, 5) == 0) b = 32'($urandom_range(1, 15));
         run_op("random", f, a, b, i[0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
